// File: rtl/jtag_tap_tracker.sv
// JTAG TCK generator and IEEE 1149.1 TAP state mirror for the mezzanine boot-config path.
// tck and tap_state change on the same clk edge, so consumers can sample either TCK edge.

`ifndef JTAG_TAP_STATE_DEFS
`define JTAG_TAP_STATE_DEFS
`define STATE_EXIT2_DR          4'h0
`define STATE_EXIT1_DR          4'h1
`define STATE_SHIFT_DR          4'h2
`define STATE_PAUSE_DR          4'h3
`define STATE_SELECT_IR_SCAN    4'h4
`define STATE_UPDATE_DR         4'h5
`define STATE_CAPTURE_DR        4'h6
`define STATE_SELECT_DR_SCAN    4'h7
`define STATE_EXIT2_IR          4'h8
`define STATE_EXIT1_IR          4'h9
`define STATE_SHIFT_IR          4'hA
`define STATE_PAUSE_IR          4'hB
`define STATE_RUN_TEST_IDLE     4'hC
`define STATE_UPDATE_IR         4'hD
`define STATE_CAPTURE_IR        4'hE
`define STATE_TEST_LOGIC_RESET  4'hF
`endif

module jtag_tap_tracker #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tms,
    output logic             tck,
    output logic             tck_rise,
    output logic             tck_fall,
    output logic [3:0]       tap_state,
    output logic             tap_valid,
    output logic [CNT_W-1:0] tck_cnt
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0]     SYNC_ONES = 3'd5;

    typedef enum logic [3:0] {
        TLR       = `STATE_TEST_LOGIC_RESET,
        RTI       = `STATE_RUN_TEST_IDLE,
        SEL_DR    = `STATE_SELECT_DR_SCAN,
        CAP_DR    = `STATE_CAPTURE_DR,
        SHIFT_DR  = `STATE_SHIFT_DR,
        EXIT1_DR  = `STATE_EXIT1_DR,
        PAUSE_DR  = `STATE_PAUSE_DR,
        EXIT2_DR  = `STATE_EXIT2_DR,
        UPDATE_DR = `STATE_UPDATE_DR,
        SEL_IR    = `STATE_SELECT_IR_SCAN,
        CAP_IR    = `STATE_CAPTURE_IR,
        SHIFT_IR  = `STATE_SHIFT_IR,
        EXIT1_IR  = `STATE_EXIT1_IR,
        PAUSE_IR  = `STATE_PAUSE_IR,
        EXIT2_IR  = `STATE_EXIT2_IR,
        UPDATE_IR = `STATE_UPDATE_IR
    } tap_state_t;

    tap_state_t       state_q;
    tap_state_t       state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       ones_q;
    logic [2:0]       ones_d;
    logic             enable_q;
    logic             div_wrap;
    logic             rise_evt;
    logic             fall_evt;
    logic             sync_hit;

    // Rise/fall events are decided combinationally so strobes land with the tck flop.
    assign div_wrap = enable && (div_cnt == DIV_LAST);
    assign rise_evt = div_wrap && !tck;
    assign fall_evt = (div_wrap && tck) || (!enable && tck);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            tck      <= 1'b0;
            tck_rise <= 1'b0;
            tck_fall <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            tck_rise <= rise_evt;
            tck_fall <= fall_evt;
            enable_q <= enable;
            if (!enable) begin
                div_cnt <= '0;
                tck     <= 1'b0;
            end else if (div_wrap) begin
                div_cnt <= '0;
                tck     <= ~tck;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_comb begin
        ones_d = ones_q;
        if (rise_evt) begin
            if (!tms) begin
                ones_d = 3'd0;
            end else if (ones_q != SYNC_ONES) begin
                ones_d = ones_q + 3'd1;
            end
        end
    end

    assign sync_hit = rise_evt && tms && (ones_d == SYNC_ONES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Five consecutive TMS=1 edges always land in TLR; the override also covers a corrupted state.
    always_comb begin
        state_d = state_q;
        if (rise_evt) begin
            case (state_q)
                TLR:       state_d = tms ? TLR       : RTI;
                RTI:       state_d = tms ? SEL_DR    : RTI;
                SEL_DR:    state_d = tms ? SEL_IR    : CAP_DR;
                SEL_IR:    state_d = tms ? TLR       : CAP_IR;
                CAP_DR:    state_d = tms ? EXIT1_DR  : SHIFT_DR;
                SHIFT_DR:  state_d = tms ? EXIT1_DR  : SHIFT_DR;
                EXIT1_DR:  state_d = tms ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:  state_d = tms ? EXIT2_DR  : PAUSE_DR;
                EXIT2_DR:  state_d = tms ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR: state_d = tms ? SEL_DR    : RTI;
                CAP_IR:    state_d = tms ? EXIT1_IR  : SHIFT_IR;
                SHIFT_IR:  state_d = tms ? EXIT1_IR  : SHIFT_IR;
                EXIT1_IR:  state_d = tms ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:  state_d = tms ? EXIT2_IR  : PAUSE_IR;
                EXIT2_IR:  state_d = tms ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR: state_d = tms ? SEL_DR    : RTI;
                default:   state_d = TLR;
            endcase
            if (sync_hit) begin
                state_d = TLR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q    <= 3'd0;
            tap_valid <= 1'b0;
        end else begin
            ones_q <= ones_d;
            if (sync_hit) begin
                tap_valid <= 1'b1;
            end
        end
    end

    // A fresh enable clears the count even if a rise would land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_cnt <= '0;
        end else if (enable && !enable_q) begin
            tck_cnt <= '0;
        end else if (rise_evt && !(&tck_cnt)) begin
            tck_cnt <= tck_cnt + CNT_W'(1);
        end
    end

    assign tap_state = state_q;

endmodule

// File: tb/tb_jtag_tap_tracker.sv
// Scoreboard bench for jtag_tap_tracker: directed TMS walks push expected post-rise
// results, and a negedge monitor pops and compares them on every tck_rise.

`ifndef JTAG_TAP_STATE_DEFS
`define JTAG_TAP_STATE_DEFS
`define STATE_EXIT2_DR          4'h0
`define STATE_EXIT1_DR          4'h1
`define STATE_SHIFT_DR          4'h2
`define STATE_PAUSE_DR          4'h3
`define STATE_SELECT_IR_SCAN    4'h4
`define STATE_UPDATE_DR         4'h5
`define STATE_CAPTURE_DR        4'h6
`define STATE_SELECT_DR_SCAN    4'h7
`define STATE_EXIT2_IR          4'h8
`define STATE_EXIT1_IR          4'h9
`define STATE_SHIFT_IR          4'hA
`define STATE_PAUSE_IR          4'hB
`define STATE_RUN_TEST_IDLE     4'hC
`define STATE_UPDATE_IR         4'hD
`define STATE_CAPTURE_IR        4'hE
`define STATE_TEST_LOGIC_RESET  4'hF
`endif

module tb_jtag_tap_tracker;

    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 16;

    localparam logic [3:0] TLR       = `STATE_TEST_LOGIC_RESET;
    localparam logic [3:0] RTI       = `STATE_RUN_TEST_IDLE;
    localparam logic [3:0] SEL_DR    = `STATE_SELECT_DR_SCAN;
    localparam logic [3:0] CAP_DR    = `STATE_CAPTURE_DR;
    localparam logic [3:0] SHIFT_DR  = `STATE_SHIFT_DR;
    localparam logic [3:0] EXIT1_DR  = `STATE_EXIT1_DR;
    localparam logic [3:0] PAUSE_DR  = `STATE_PAUSE_DR;
    localparam logic [3:0] EXIT2_DR  = `STATE_EXIT2_DR;
    localparam logic [3:0] UPDATE_DR = `STATE_UPDATE_DR;
    localparam logic [3:0] SEL_IR    = `STATE_SELECT_IR_SCAN;
    localparam logic [3:0] CAP_IR    = `STATE_CAPTURE_IR;
    localparam logic [3:0] SHIFT_IR  = `STATE_SHIFT_IR;
    localparam logic [3:0] EXIT1_IR  = `STATE_EXIT1_IR;
    localparam logic [3:0] PAUSE_IR  = `STATE_PAUSE_IR;
    localparam logic [3:0] EXIT2_IR  = `STATE_EXIT2_IR;
    localparam logic [3:0] UPDATE_IR = `STATE_UPDATE_IR;

    typedef struct packed {
        logic [3:0]       state;
        logic             valid;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             tms;
    logic             tck;
    logic             tck_rise;
    logic             tck_fall;
    logic [3:0]       tap_state;
    logic             tap_valid;
    logic [CNT_W-1:0] tck_cnt;

    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         exp_cnt = 0;
    int         shift_seen = 0;
    logic       prev_tck;
    logic [3:0] prev_state;

    jtag_tap_tracker #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .tms      (tms),
        .tck      (tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tap_state(tap_state),
        .tap_valid(tap_valid),
        .tck_cnt  (tck_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: strobe/transition agreement every cycle, scoreboard pop on each rise.
    always @(negedge clk) begin
        if (rst) begin
            prev_tck   = 1'b0;
            prev_state = TLR;
        end else begin
            if (tck_rise || (tck && !prev_tck)) begin
                checkOutput("rise_strobe", 32'(tck_rise), 32'(tck & ~prev_tck));
            end
            if (tck_fall || (!tck && prev_tck)) begin
                checkOutput("fall_strobe", 32'(tck_fall), 32'(~tck & prev_tck));
            end
            if (tck_rise) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_rise: actual state %0h, required no rise", tap_state);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("tap_state", 32'(tap_state), 32'(e.state));
                    checkOutput("tap_valid", 32'(tap_valid), 32'(e.valid));
                    checkOutput("tck_cnt",   32'(tck_cnt),   32'(e.cnt));
                end
                if (prev_state == SHIFT_DR) shift_seen++;
            end
            prev_tck   = tck;
            prev_state = tap_state;
        end
    end

    // One TCK rising edge: queue the expected result, present tms, time the rise and high phase.
    task automatic applyStimulus(input logic t, input logic [3:0] st, input logic v,
                                 input int req_rise, input bit wait_fall);
        int n;
        exp_t e;
        exp_cnt++;
        e.state = st;
        e.valid = v;
        e.cnt   = CNT_W'(exp_cnt);
        exp_q.push_back(e);
        tms = t;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tck_rise && n < 50);
        checkOutput("cycles_to_rise", 32'(n), 32'(req_rise));
        if (wait_fall) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (tck && n < 50);
            checkOutput("tck_high_cycles", 32'(n), 32'(CLK_DIV));
        end
    endtask

    task automatic applyReset();
        enable = 1'b0;
        rst    = 1'b1;
        #1;
        checkOutput("rst_tck",       32'(tck),       32'(0));
        checkOutput("rst_tck_rise",  32'(tck_rise),  32'(0));
        checkOutput("rst_tck_fall",  32'(tck_fall),  32'(0));
        checkOutput("rst_tap_state", 32'(tap_state), 32'(TLR));
        checkOutput("rst_tap_valid", 32'(tap_valid), 32'(0));
        checkOutput("rst_tck_cnt",   32'(tck_cnt),   32'(0));
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tms    = 1'b1;
        enable = 1'b0;
        applyReset();

        // Five TMS=1 edges from reset: sync on the fifth, count reads 5.
        enable = 1'b1;
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, TLR, (i == 5), 4, 1'b1);

        // DR scan with 32 held SHIFT_DR edges.
        applyStimulus(1'b0, RTI,      1'b1, 4, 1'b1);
        applyStimulus(1'b1, SEL_DR,   1'b1, 4, 1'b1);
        applyStimulus(1'b0, CAP_DR,   1'b1, 4, 1'b1);
        applyStimulus(1'b0, SHIFT_DR, 1'b1, 4, 1'b1);
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, SHIFT_DR, 1'b1, 4, 1'b1);
        applyStimulus(1'b1, EXIT1_DR,  1'b1, 4, 1'b1);
        applyStimulus(1'b1, UPDATE_DR, 1'b1, 4, 1'b1);
        applyStimulus(1'b0, RTI,       1'b1, 4, 1'b1);
        checkOutput("shift_dr_pre_edges", 32'(shift_seen), 32'(33));

        // IR path through pause.
        applyStimulus(1'b1, SEL_DR,    1'b1, 4, 1'b1);
        applyStimulus(1'b1, SEL_IR,    1'b1, 4, 1'b1);
        applyStimulus(1'b0, CAP_IR,    1'b1, 4, 1'b1);
        applyStimulus(1'b0, SHIFT_IR,  1'b1, 4, 1'b1);
        applyStimulus(1'b1, EXIT1_IR,  1'b1, 4, 1'b1);
        applyStimulus(1'b0, PAUSE_IR,  1'b1, 4, 1'b1);
        applyStimulus(1'b1, EXIT2_IR,  1'b1, 4, 1'b1);
        applyStimulus(1'b1, UPDATE_IR, 1'b1, 4, 1'b1);

        // Fresh reset, walk to PAUSE_DR, then five 1s resync to TLR.
        applyReset();
        enable = 1'b1;
        applyStimulus(1'b0, RTI,       1'b0, 4, 1'b1);
        applyStimulus(1'b1, SEL_DR,    1'b0, 4, 1'b1);
        applyStimulus(1'b0, CAP_DR,    1'b0, 4, 1'b1);
        applyStimulus(1'b1, EXIT1_DR,  1'b0, 4, 1'b1);
        applyStimulus(1'b0, PAUSE_DR,  1'b0, 4, 1'b1);
        applyStimulus(1'b1, EXIT2_DR,  1'b0, 4, 1'b1);
        applyStimulus(1'b1, UPDATE_DR, 1'b0, 4, 1'b1);
        applyStimulus(1'b1, SEL_DR,    1'b0, 4, 1'b1);
        applyStimulus(1'b1, SEL_IR,    1'b0, 4, 1'b1);
        applyStimulus(1'b1, TLR,       1'b1, 4, 1'b1);

        // Sync broken by a single 0, then restored by a fifth consecutive 1.
        applyReset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, TLR, 1'b0, 4, 1'b1);
        applyStimulus(1'b0, RTI,    1'b0, 4, 1'b1);
        applyStimulus(1'b1, SEL_DR, 1'b0, 4, 1'b1);
        applyStimulus(1'b1, SEL_IR, 1'b0, 4, 1'b1);
        applyStimulus(1'b1, TLR,    1'b0, 4, 1'b1);
        applyStimulus(1'b1, TLR,    1'b0, 4, 1'b1);
        applyStimulus(1'b1, TLR,    1'b1, 4, 1'b1);

        // Drop enable while tck is high in SHIFT_DR.
        applyStimulus(1'b0, RTI,      1'b1, 4, 1'b1);
        applyStimulus(1'b1, SEL_DR,   1'b1, 4, 1'b1);
        applyStimulus(1'b0, CAP_DR,   1'b1, 4, 1'b1);
        applyStimulus(1'b0, SHIFT_DR, 1'b1, 4, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("dis_tck",       32'(tck),       32'(0));
        checkOutput("dis_tck_fall",  32'(tck_fall),  32'(1));
        checkOutput("dis_tap_state", 32'(tap_state), 32'(SHIFT_DR));
        repeat (3) @(negedge clk);
        checkOutput("off_tck",       32'(tck),       32'(0));
        checkOutput("off_tck_fall",  32'(tck_fall),  32'(0));
        checkOutput("off_tap_state", 32'(tap_state), 32'(SHIFT_DR));
        checkOutput("off_tap_valid", 32'(tap_valid), 32'(1));
        checkOutput("off_tck_cnt",   32'(tck_cnt),   32'(exp_cnt));
        enable  = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        checkOutput("reen_tck_cnt", 32'(tck_cnt), 32'(0));
        checkOutput("reen_tck",     32'(tck),     32'(0));
        applyStimulus(1'b0, SHIFT_DR, 1'b1, 3, 1'b1);

        // Async reset between clk edges while tck is high in SHIFT_DR.
        applyStimulus(1'b0, SHIFT_DR, 1'b1, 4, 1'b0);
        #2;
        applyReset();
        enable = 1'b1;
        applyStimulus(1'b1, TLR, 1'b0, 4, 1'b1);
        applyStimulus(1'b0, RTI, 1'b0, 4, 1'b1);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
